// File: rtl/bcd_clock_hms.sv
// BCD time-of-day counter: seconds, minutes, hours (24 h or 12 h + pm).
// Ports: clk, rst_n, ce, L/sel/DI load, QS/QM/QH/pm/QHMS, carries, load_err.
// Optional alarm (al_we, AL, al_clr, alarm) with `define BCD_CLOCK_ALARM_EN.
module bcd_clock_hms #(
    parameter bit MODE_24H = 1'b1,
    parameter bit HAS_SEC  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        L,
    input  logic [1:0]  sel,
    input  logic [7:0]  DI,
`ifdef BCD_CLOCK_ALARM_EN
    input  logic        al_we,
    input  logic [16:0] AL,
    input  logic        al_clr,
    output logic        alarm,
`endif
    output logic [7:0]  QS,
    output logic [7:0]  QM,
    output logic [7:0]  QH,
    output logic        pm,
    output logic [23:0] QHMS,
    output logic        co_s,
    output logic        co_m,
    output logic        co,
    output logic        load_err
);

    localparam logic [7:0] H_RST = MODE_24H ? 8'h00 : 8'h12;

    logic [7:0] s_q, m_q, h_q;
    logic [7:0] s_d, m_d, h_d;
    logic       pm_q, pm_d;
    logic       err_q, ld_ok;
    logic       sec_end, hr_end;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_h24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_h12(input logic [7:0] v);
        if (v == 8'h12)
            return 8'h01;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic ok60(input logic [6:0] d);
        return (d[6:4] <= 3'd5) && (d[3:0] <= 4'd9);
    endfunction

    function automatic logic ok24(input logic [6:0] d);
        return (d[3:0] <= 4'd9) &&
               ((d[6:4] < 3'd2) || (d[6:4] == 3'd2 && d[3:0] <= 4'd3));
    endfunction

    function automatic logic ok12(input logic [6:0] d);
        return (d[6:4] == 3'd0 && d[3:0] != 4'd0 && d[3:0] <= 4'd9) ||
               (d[6:4] == 3'd1 && d[3:0] <= 4'd2);
    endfunction

    // Without a seconds stage every tick is a minute boundary.
    assign sec_end = HAS_SEC ? (s_q == 8'h59) : 1'b1;
    assign hr_end  = MODE_24H ? (h_q == 8'h23)
                              : (h_q == 8'h11 && pm_q);
    assign co_s    = ~L & ce & sec_end;
    assign co_m    = co_s & (m_q == 8'h59);
    assign co      = co_m & hr_end;

    always_comb begin
        s_d   = s_q;
        m_d   = m_q;
        h_d   = h_q;
        pm_d  = pm_q;
        ld_ok = 1'b0;
        if (L) begin
            // Chain frozen; only a validated field is written.
            unique case (1'b1)
                sel == 2'd0: begin
                    if (HAS_SEC && ok60(DI[6:0])) begin
                        ld_ok = 1'b1;
                        s_d   = {1'b0, DI[6:0]};
                    end
                end
                sel == 2'd1: begin
                    if (ok60(DI[6:0])) begin
                        ld_ok = 1'b1;
                        m_d   = {1'b0, DI[6:0]};
                    end
                end
                sel == 2'd2: begin
                    if (MODE_24H) begin
                        if (ok24(DI[6:0])) begin
                            ld_ok = 1'b1;
                            h_d   = {1'b0, DI[6:0]};
                        end
                    end else if (ok12(DI[6:0])) begin
                        ld_ok = 1'b1;
                        h_d   = {1'b0, DI[6:0]};
                        pm_d  = DI[7];
                    end
                end
                default: ld_ok = 1'b0;
            endcase
        end else begin
            if (HAS_SEC && ce)
                s_d = inc60(s_q);
            if (co_s)
                m_d = inc60(m_q);
            if (co_m) begin
                if (MODE_24H) begin
                    h_d = inc_h24(h_q);
                end else begin
                    h_d = inc_h12(h_q);
                    if (h_q == 8'h11)
                        pm_d = ~pm_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 8'h00;
            m_q   <= 8'h00;
            h_q   <= H_RST;
            pm_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            m_q   <= m_d;
            h_q   <= h_d;
            pm_q  <= pm_d;
            err_q <= L & ~ld_ok;
        end
    end

`ifdef BCD_CLOCK_ALARM_EN
    localparam logic [16:0] AL_RST = MODE_24H ? 17'h00000
                                              : {1'b0, 8'h12, 8'h00};

    logic [16:0] al_q;
    logic        alarm_q;
    logic        al_pm_now, al_pm_reg, al_hit;

    // pm takes part in the match only in 12 h mode.
    assign al_pm_now = MODE_24H ? 1'b0 : pm_d;
    assign al_pm_reg = MODE_24H ? 1'b0 : al_q[16];
    assign al_hit    = co_s &&
                       ({al_pm_now, h_d, m_d} == {al_pm_reg, al_q[15:0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_q    <= AL_RST;
            alarm_q <= 1'b0;
        end else begin
            if (al_we)
                al_q <= AL;
            if (al_clr)
                alarm_q <= 1'b0;
            else if (al_hit)
                alarm_q <= 1'b1;
        end
    end

    assign alarm = alarm_q;
`endif

    assign QS       = s_q;
    assign QM       = m_q;
    assign QH       = h_q;
    assign pm       = MODE_24H ? 1'b0 : pm_q;
    assign QHMS     = {h_q, m_q, s_q};
    assign load_err = err_q;

endmodule
